// File: rtl/trap_ctrl_pkg.sv
// Shared trap definitions: CSR exp encodings, mcause values, FSM state codes and mip/mstatus bit positions.
package trap_ctrl_pkg;

    localparam int MSTATUS_MIE = 3;
    localparam int MIP_MSI     = 3;
    localparam int MIP_MTI     = 7;
    localparam int MIP_MEI     = 11;

    localparam logic [5:0] EXP_NONE = 6'b000000;
    localparam logic [5:0] EXP_MRET = 6'b100000;
    localparam logic [5:0] EXP_IRQ  = 6'b000001;

    localparam logic [31:0] CAUSE_MEI = 32'h8000_000B;
    localparam logic [31:0] CAUSE_MSI = 32'h8000_0003;
    localparam logic [31:0] CAUSE_MTI = 32'h8000_0007;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_COMMIT   = 2'd1,
        ST_REDIRECT = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        EV_EXC  = 2'd0,
        EV_MRET = 2'd1,
        EV_IRQ  = 2'd2
    } kind_t;

    // Exception index idx (1..6) sits in exp[4:1].
    function automatic logic [5:0] exc_exp(input logic [3:0] idx);
        return {1'b0, idx, 1'b0};
    endfunction

    function automatic logic [4:0] exc_cause(input logic [2:0] bit_pos);
        case (bit_pos)
            3'd0:    return 5'd0;
            3'd1:    return 5'd2;
            3'd2:    return 5'd3;
            3'd3:    return 5'd11;
            3'd4:    return 5'd4;
            3'd5:    return 5'd6;
            default: return 5'd0;
        endcase
    endfunction

endpackage

// File: rtl/trap_ctrl_irq_sync.sv
// Multi-flop synchronizer for one asynchronous interrupt level line.
module trap_ctrl_irq_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/trap_ctrl.sv
// Trap sequencer: picks one WB exception / mret / interrupt, then drives CSR commit, flush and fetch redirect.
module trap_ctrl
    import trap_ctrl_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wb_valid,
    input  logic [XLEN-1:0] wb_pc,
    input  logic [5:0]      wb_exc,
    input  logic            wb_mret,
    input  logic            irq_ext,
    input  logic            irq_timer,
    input  logic            irq_soft,
    input  logic [XLEN-1:0] mstatus,
    input  logic [XLEN-1:0] mie,
    input  logic [XLEN-1:0] mtvec,
    input  logic [XLEN-1:0] mepc,
    output logic [5:0]      exp,
    output logic [XLEN-1:0] cause,
    output logic [XLEN-1:0] epc,
    output logic [XLEN-1:0] mip,
    output logic            flush,
    output logic            stall,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    input  logic            redirect_ready,
    output logic [1:0]      fsm_state
);

    state_t          state_q, state_d;
    kind_t           kind_q, ev_kind;
    logic            meip, mtip, msip;
    logic            ev_hit, irq_en;
    logic [5:0]      ev_exp;
    logic [XLEN-1:0] ev_cause, ev_epc, irq_pend, base, target;
    logic            unused_mstatus;

    trap_ctrl_irq_sync #(.STAGES(SYNC_STAGES)) u_sync_ext (.clk(clk), .rst(rst), .d(irq_ext),   .q(meip));
    trap_ctrl_irq_sync #(.STAGES(SYNC_STAGES)) u_sync_tmr (.clk(clk), .rst(rst), .d(irq_timer), .q(mtip));
    trap_ctrl_irq_sync #(.STAGES(SYNC_STAGES)) u_sync_sft (.clk(clk), .rst(rst), .d(irq_soft),  .q(msip));

    always_comb begin
        mip          = '0;
        mip[MIP_MEI] = meip;
        mip[MIP_MTI] = mtip;
        mip[MIP_MSI] = msip;
    end

    assign irq_pend       = mip & mie;
    assign irq_en         = mstatus[MSTATUS_MIE] && (|irq_pend);
    assign unused_mstatus = ^{mstatus[XLEN-1:MSTATUS_MIE+1], mstatus[MSTATUS_MIE-1:0]};

    // Priority: exception > mret > interrupt; descending loop leaves the lowest set bit winning.
    always_comb begin
        ev_hit   = 1'b0;
        ev_kind  = EV_EXC;
        ev_exp   = EXP_NONE;
        ev_cause = '0;
        ev_epc   = wb_pc;
        if (wb_exc != 6'b0) begin
            ev_hit = 1'b1;
            for (int b = 5; b >= 0; b--) begin
                if (wb_exc[b]) begin
                    ev_exp   = exc_exp(4'(b + 1));
                    ev_cause = XLEN'(exc_cause(3'(b)));
                end
            end
        end else if (wb_mret) begin
            ev_hit  = 1'b1;
            ev_kind = EV_MRET;
            ev_exp  = EXP_MRET;
            ev_epc  = '0;
        end else if (irq_en) begin
            ev_hit  = 1'b1;
            ev_kind = EV_IRQ;
            ev_exp  = EXP_IRQ;
            if (irq_pend[MIP_MEI])      ev_cause = XLEN'(CAUSE_MEI);
            else if (irq_pend[MIP_MSI]) ev_cause = XLEN'(CAUSE_MSI);
            else                        ev_cause = XLEN'(CAUSE_MTI);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     if (wb_valid && ev_hit) state_d = ST_COMMIT;
            ST_COMMIT:   state_d = ST_REDIRECT;
            ST_REDIRECT: if (redirect_ready) state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    // Sampled at the COMMIT->REDIRECT edge; mtvec/mepc are not touched by the trap write itself.
    assign base = {mtvec[XLEN-1:2], 2'b00};
    always_comb begin
        target = base;
        if (kind_q == EV_MRET)
            target = mepc;
        else if (kind_q == EV_IRQ && mtvec[1:0] == 2'b01)
            target = base + XLEN'({cause[3:0], 2'b00});
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            exp            <= EXP_NONE;
            cause          <= '0;
            epc            <= '0;
            flush          <= 1'b0;
            stall          <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            kind_q         <= EV_EXC;
        end else begin
            case (state_d)
                ST_COMMIT: begin
                    exp            <= ev_exp;
                    cause          <= ev_cause;
                    epc            <= ev_epc;
                    kind_q         <= ev_kind;
                    flush          <= 1'b1;
                    stall          <= 1'b1;
                    redirect_valid <= 1'b0;
                end
                ST_REDIRECT: begin
                    exp            <= EXP_NONE;
                    cause          <= '0;
                    epc            <= '0;
                    flush          <= 1'b1;
                    stall          <= 1'b1;
                    redirect_valid <= 1'b1;
                    if (state_q == ST_COMMIT) redirect_pc <= target;
                end
                default: begin
                    exp            <= EXP_NONE;
                    cause          <= '0;
                    epc            <= '0;
                    flush          <= 1'b0;
                    stall          <= 1'b0;
                    redirect_valid <= 1'b0;
                    redirect_pc    <= '0;
                end
            endcase
        end
    end

    assign fsm_state = state_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl: hand-computed exp/cause/epc/redirect values for each trap scenario.
module tb_trap_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_valid, wb_mret, irq_ext, irq_timer, irq_soft, redirect_ready;
    logic [31:0] wb_pc, mstatus, mie, mtvec, mepc;
    logic [5:0]  wb_exc;
    logic [5:0]  exp;
    logic [31:0] cause, epc, mip, redirect_pc;
    logic        flush, stall, redirect_valid;
    logic [1:0]  fsm_state;

    int n_vec = 0;
    int n_err = 0;

    trap_ctrl #(.XLEN(32), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_exc(wb_exc),
        .wb_mret(wb_mret), .irq_ext(irq_ext), .irq_timer(irq_timer), .irq_soft(irq_soft),
        .mstatus(mstatus), .mie(mie), .mtvec(mtvec), .mepc(mepc), .exp(exp), .cause(cause),
        .epc(epc), .mip(mip), .flush(flush), .stall(stall), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .redirect_ready(redirect_ready), .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Event inputs already applied; walks COMMIT, REDIRECT and the handshake back to IDLE.
    task automatic run_event(input string tag, input logic [5:0] e_exp, input logic [31:0] e_cause,
                             input logic [31:0] e_epc, input logic [31:0] e_rpc);
        tick();
        check({tag, ".exp"},   32'(exp), 32'(e_exp));
        check({tag, ".cause"}, cause, e_cause);
        check({tag, ".epc"},   epc, e_epc);
        check({tag, ".fl_st"}, {30'd0, flush, stall}, 32'd3);
        check({tag, ".rv0"},   32'(redirect_valid), 32'd0);
        wb_valid = 1'b0;
        tick();
        check({tag, ".exp0"},  32'(exp), 32'd0);
        check({tag, ".rv1"},   32'(redirect_valid), 32'd1);
        check({tag, ".rpc"},   redirect_pc, e_rpc);
        redirect_ready = 1'b1;
        tick();
        redirect_ready = 1'b0;
        check({tag, ".idle"},  {27'd0, redirect_valid, flush, stall, fsm_state}, 32'd0);
    endtask

    initial begin
        rst = 1'b0; wb_valid = 1'b0; wb_pc = '0; wb_exc = '0; wb_mret = 1'b0;
        irq_ext = 1'b0; irq_timer = 1'b0; irq_soft = 1'b0; redirect_ready = 1'b0;
        mstatus = '0; mie = '0; mtvec = '0; mepc = '0;
        tick(); tick();
        check("rst.outs", {26'd0, exp}, 32'd0);
        check("rst.ctl",  {27'd0, flush, stall, redirect_valid, fsm_state}, 32'd0);
        check("rst.mip",  mip, 32'd0);
        rst = 1'b1;
        tick();

        // ecall to direct mtvec
        wb_valid = 1'b1; wb_exc = 6'b001000; wb_pc = 32'h100; mtvec = 32'h200;
        run_event("ecall", 6'b001000, 32'd11, 32'h100, 32'h200);

        // illegal+ebreak with mret and irq_ext pending: illegal wins
        wb_valid = 1'b1; wb_exc = 6'b000110; wb_mret = 1'b1; wb_pc = 32'h120;
        irq_ext = 1'b1; mie = 32'h800; mstatus = 32'h8;
        run_event("illegal", 6'b000100, 32'd2, 32'h120, 32'h200);
        wb_exc = '0; wb_mret = 1'b0; irq_ext = 1'b0; mie = '0;
        tick(); tick(); tick();

        // ld-misalign beats st-misalign; exceptions ignore vectored mode
        mtvec = 32'h301;
        wb_valid = 1'b1; wb_exc = 6'b110000; wb_pc = 32'h140;
        run_event("ldmis", 6'b001010, 32'd4, 32'h140, 32'h300);
        wb_valid = 1'b1; wb_exc = 6'b100000; wb_pc = 32'h144;
        run_event("stmis", 6'b001100, 32'd6, 32'h144, 32'h300);
        wb_valid = 1'b1; wb_exc = 6'b000001; wb_mret = 1'b1; wb_pc = 32'h148;
        run_event("imis", 6'b000010, 32'd0, 32'h148, 32'h300);
        wb_exc = '0; wb_mret = 1'b0;

        // exception with wb_valid low is ignored
        wb_exc = 6'b001000;
        tick(); tick();
        check("novalid", {24'd0, exp, fsm_state}, 32'd0);
        wb_exc = '0;

        // vectored timer interrupt after synchronizer latency
        irq_timer = 1'b1; mie = 32'h80; mstatus = 32'h8; mtvec = 32'h301;
        wb_valid = 1'b1; wb_pc = 32'h500;
        tick();
        check("mti.mip_s1", mip, 32'h0);
        tick();
        check("mti.mip_s2", mip, 32'h80);
        check("mti.noexp",  32'(exp), 32'd0);
        run_event("mti", 6'b000001, 32'h8000_0007, 32'h500, 32'h31C);

        // global MIE clear: no trap but mip still visible
        mstatus = 32'h0; irq_timer = 1'b1; wb_valid = 1'b1; wb_pc = 32'h600;
        tick(); tick(); tick(); tick();
        check("mie0.mip",   mip, 32'h80);
        check("mie0.quiet", {24'd0, exp, stall, redirect_valid}, 32'd0);
        wb_valid = 1'b0; irq_timer = 1'b0; mie = '0;
        tick(); tick(); tick();

        // MEI beats MSI, vectored offset 4*11
        irq_ext = 1'b1; irq_soft = 1'b1; mie = 32'h888; mstatus = 32'h8; mtvec = 32'h301;
        wb_valid = 1'b1; wb_pc = 32'h700;
        tick(); tick();
        run_event("mei", 6'b000001, 32'h8000_000B, 32'h700, 32'h32C);
        irq_ext = 1'b0;
        tick(); tick(); tick();

        // MSI with mtvec mode 11 treated as direct
        mtvec = 32'h203; wb_valid = 1'b1; wb_pc = 32'h704;
        run_event("msi", 6'b000001, 32'h8000_0003, 32'h704, 32'h200);
        irq_soft = 1'b0; mie = '0;
        tick(); tick(); tick();

        // mret with redirect_ready held low
        mepc = 32'h444; wb_valid = 1'b1; wb_mret = 1'b1; wb_pc = 32'h800;
        tick();
        check("mret.exp",  32'(exp), 32'h20);
        check("mret.ce",   cause | epc, 32'd0);
        wb_valid = 1'b0; wb_mret = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("mret.hold_rv",  32'(redirect_valid), 32'd1);
            check("mret.hold_rpc", redirect_pc, 32'h444);
        end
        redirect_ready = 1'b1;
        tick();
        redirect_ready = 1'b0;
        check("mret.idle", {29'd0, redirect_valid, fsm_state}, 32'd0);

        // async reset during REDIRECT
        mtvec = 32'h200; wb_valid = 1'b1; wb_exc = 6'b001000; wb_pc = 32'h900;
        tick();
        wb_valid = 1'b0; wb_exc = '0;
        tick();
        check("rstmid.rv", 32'(redirect_valid), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("rstmid.ctl", {27'd0, flush, stall, redirect_valid, fsm_state}, 32'd0);
        check("rstmid.rpc", redirect_pc, 32'd0);
        tick();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("rstmid.noexp", {24'd0, exp, fsm_state}, 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
